// File: rtl/seq_detector_param.sv
// Parametrised serial-pattern detector with a runtime-loadable pattern,
// selectable overlapping/non-overlapping detection and a saturating match counter.
module seq_detector_param #(
    parameter int unsigned      PAT_W   = 3,
    parameter logic [PAT_W-1:0] DEF_PAT = 3'b111,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  shift_r;
    logic [PAT_W-1:0]  pattern_r;
    logic [FILL_W-1:0] fill_r;
    logic              match_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              sat_r;

    logic [PAT_W-1:0]  shift_cand_s;
    logic [FILL_W-1:0] fill_cand_s;
    logic              hit_s;

    logic [PAT_W-1:0]  shift_nx_s;
    logic [PAT_W-1:0]  pattern_nx_s;
    logic [FILL_W-1:0] fill_nx_s;
    logic              match_nx_s;
    logic [CNT_W-1:0]  cnt_nx_s;
    logic              sat_nx_s;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // Candidate shift/fill for an accepted bit and the resulting hit decision.
    always_comb begin
        shift_cand_s = {shift_r[PAT_W-2:0], din};
        if (fill_r == FILL_FULL) begin
            fill_cand_s = fill_r;
        end else begin
            fill_cand_s = fill_r + FILL_ONE;
        end
        hit_s = en && !pat_load && (fill_cand_s == FILL_FULL) && (shift_cand_s == pattern_r);
    end

    // Next-state for detector datapath; pat_load takes priority over en.
    always_comb begin
        shift_nx_s   = shift_r;
        pattern_nx_s = pattern_r;
        fill_nx_s    = fill_r;
        match_nx_s   = 1'b0;
        if (pat_load) begin
            pattern_nx_s = pat_in;
            fill_nx_s    = FILL_ZERO;
        end else if (en) begin
            shift_nx_s = shift_cand_s;
            match_nx_s = hit_s;
            if (hit_s && !overlap) begin
                fill_nx_s = FILL_ZERO;
            end else begin
                fill_nx_s = fill_cand_s;
            end
        end else begin
            match_nx_s = 1'b0;
        end
    end

    // Next-state for the match counter; a clear beats a coincident hit.
    always_comb begin
        cnt_nx_s = cnt_r;
        sat_nx_s = sat_r;
        if (cnt_clr) begin
            cnt_nx_s = CNT_ZERO;
            sat_nx_s = 1'b0;
        end else if (hit_s) begin
            cnt_nx_s = sat_inc(cnt_r);
            sat_nx_s = sat_r || (cnt_nx_s == CNT_MAX);
        end else begin
            cnt_nx_s = cnt_r;
            sat_nx_s = sat_r;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_r   <= {PAT_W{1'b0}};
            pattern_r <= DEF_PAT;
            fill_r    <= FILL_ZERO;
            match_r   <= 1'b0;
            cnt_r     <= CNT_ZERO;
            sat_r     <= 1'b0;
        end else begin
            shift_r   <= shift_nx_s;
            pattern_r <= pattern_nx_s;
            fill_r    <= fill_nx_s;
            match_r   <= match_nx_s;
            cnt_r     <= cnt_nx_s;
            sat_r     <= sat_nx_s;
        end
    end

    assign match     = match_r;
    assign match_cnt = cnt_r;
    assign cnt_sat   = sat_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a vector table for the main stream
// cases plus hand-written sequences for gaps, saturation and mid-stream reset.
module tb_seq_detector_param;

    logic       clk;
    logic       reset;
    logic       en;
    logic       din;
    logic       overlap;
    logic       pat_load;
    logic [2:0] pat_in;
    logic       cnt_clr;
    logic       match;
    logic [7:0] match_cnt;
    logic       cnt_sat;
    logic       match2;
    logic [1:0] match_cnt2;
    logic       cnt_sat2;

    int n_vec = 0;
    int n_err = 0;

    seq_detector_param #(.PAT_W(3), .DEF_PAT(3'b111), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .match(match), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_detector_param #(.PAT_W(3), .DEF_PAT(3'b111), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .match(match2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       en;
        logic       din;
        logic       ovl;
        logic       ld;
        logic [2:0] pin;
        logic       clr;
        logic       m;
        logic [7:0] cnt;
        logic       sat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic e, input logic d, input logic o, input logic l,
                                input logic [2:0] p, input logic c,
                                input logic m, input logic [7:0] n, input logic s);
        vec_t v;
        v.en = e; v.din = d; v.ovl = o; v.ld = l; v.pin = p; v.clr = c;
        v.m = m; v.cnt = n; v.sat = s;
        return v;
    endfunction

    task automatic check(input string nm, input logic am, input logic [31:0] ac, input logic as_,
                         input logic em, input logic [31:0] ec, input logic es);
        n_vec++;
        if (am !== em || ac !== ec || as_ !== es) begin
            n_err++;
            $display("FAIL %s: got match=%0b cnt=%0d sat=%0b, want match=%0b cnt=%0d sat=%0b",
                     nm, am, ac, as_, em, ec, es);
        end
    endtask

    task automatic step(input logic e, input logic d, input logic o, input logic l,
                        input logic [2:0] p, input logic c);
        en = e; din = d; overlap = o; pat_load = l; pat_in = p; cnt_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; din = 1'b0; overlap = 1'b1;
        pat_load = 1'b0; pat_in = 3'b000; cnt_clr = 1'b0;

        // test 1: overlap, five 1s
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0,
                              (i >= 2) ? 1'b1 : 1'b0, (i >= 2) ? 8'(i - 1) : 8'd0, 1'b0));
        // test 2: restart, non-overlap, six 1s
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 8'd0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 8'd1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 8'd2, 1'b0));
        // test 3a: load 101, overlap, 1,0,1,0,1
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 3'b101, 1'b1, 1'b0, 8'd0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 8'd1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'd1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 8'd2, 1'b0));
        // test 3b: reload 101, non-overlap
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 8'd2, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd2, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd2, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 8'd3, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd3, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd3, 1'b0));
        // bit order: pattern 110 matches 1,1,0 in arrival order
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 3'b110, 1'b0, 1'b0, 8'd3, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'd3, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'd3, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 8'd4, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'd4, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'd4, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 8'd5, 1'b0));
        // pat_load beats en: din=1 on the load cycle is not counted as a bit
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 8'd5, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'd5, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'd5, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 8'd6, 1'b0));

        #12;
        check("reset_main", match, 32'(match_cnt), cnt_sat, 1'b0, 32'd0, 1'b0);
        check("reset_sat", match2, 32'(match_cnt2), cnt_sat2, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].din, vecs[i].ovl, vecs[i].ld, vecs[i].pin, vecs[i].clr);
            check($sformatf("vec%0d", i), match, 32'(match_cnt), cnt_sat,
                  vecs[i].m, 32'(vecs[i].cnt), vecs[i].sat);
        end

        // test 4: 1,1, four en=0 cycles with din=0, then 1
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'b111, 1'b1);
        check("gap_load", match, 32'(match_cnt), cnt_sat, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        check("gap_pre", match, 32'(match_cnt), cnt_sat, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
            check($sformatf("gap_idle%0d", i), match, 32'(match_cnt), cnt_sat, 1'b0, 32'd0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        check("gap_hit", match, 32'(match_cnt), cnt_sat, 1'b1, 32'd1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        check("gap_pulse_end", match, 32'(match_cnt), cnt_sat, 1'b0, 32'd1, 1'b0);

        // test 5: 2-bit counter saturation and clear-vs-hit
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'b111, 1'b1);
        check("sat_load", match2, 32'(match_cnt2), cnt_sat2, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
            check($sformatf("sat_bit%0d", i + 1), match2, 32'(match_cnt2), cnt_sat2,
                  (i >= 2) ? 1'b1 : 1'b0,
                  (i < 2) ? 32'd0 : ((i < 5) ? 32'(i - 1) : 32'd3),
                  (i >= 4) ? 1'b1 : 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
        check("sat_clr_hit", match2, 32'(match_cnt2), cnt_sat2, 1'b1, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        check("sat_after_clr", match2, 32'(match_cnt2), cnt_sat2, 1'b1, 32'd1, 1'b0);

        // test 6: mid-stream asynchronous reset restores DEF_PAT and clears fill
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'b111, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        check("rst_prehit", match, 32'(match_cnt), cnt_sat, 1'b1, 32'd1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        check("rst_pre", match, 32'(match_cnt), cnt_sat, 1'b0, 32'd1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async", match, 32'(match_cnt), cnt_sat, 1'b0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", match, 32'(match_cnt), cnt_sat, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        check("rst_bit1", match, 32'(match_cnt), cnt_sat, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        check("rst_bit2", match, 32'(match_cnt), cnt_sat, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        check("rst_bit3", match, 32'(match_cnt), cnt_sat, 1'b1, 32'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
